// File: rtl/pipe_tag_tracker_if.sv
// Forwarding-side tag bundle between the ID/EX/MEM/WB tag tracker and its users.
// Optional TAG_PERF_CNT_EN adds the stall/flush performance counters.
interface pipe_tag_tracker_if #(
  parameter int unsigned REG_AW = 5
);
  logic              ID_Valid;
  logic [REG_AW-1:0] ID_Rs1;
  logic [REG_AW-1:0] ID_Rs2;
  logic              ID_UseRs1;
  logic              ID_UseRs2;
  logic [REG_AW-1:0] ID_Rd;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              Flush_i;
  logic              Hold_i;

  logic [REG_AW-1:0] IDEX_Rs1;
  logic [REG_AW-1:0] IDEX_Rs2;
  logic [REG_AW-1:0] EXMEM_Rd;
  logic              EXMEM_RegWrite;
  logic [REG_AW-1:0] MEMWB_Rd;
  logic              MEMWB_RegWrite;
  logic              Stall_o;
  logic              PCWrite_o;
  logic              IFIDWrite_o;

`ifdef TAG_PERF_CNT_EN
  logic [31:0]       StallCnt_o;
  logic [31:0]       FlushCnt_o;

  modport master (
    output ID_Valid, ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, ID_Rd,
           ID_RegWrite, ID_MemRead, Flush_i, Hold_i,
    input  IDEX_Rs1, IDEX_Rs2, EXMEM_Rd, EXMEM_RegWrite, MEMWB_Rd,
           MEMWB_RegWrite, Stall_o, PCWrite_o, IFIDWrite_o,
           StallCnt_o, FlushCnt_o
  );

  modport slave (
    input  ID_Valid, ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, ID_Rd,
           ID_RegWrite, ID_MemRead, Flush_i, Hold_i,
    output IDEX_Rs1, IDEX_Rs2, EXMEM_Rd, EXMEM_RegWrite, MEMWB_Rd,
           MEMWB_RegWrite, Stall_o, PCWrite_o, IFIDWrite_o,
           StallCnt_o, FlushCnt_o
  );
`else
  modport master (
    output ID_Valid, ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, ID_Rd,
           ID_RegWrite, ID_MemRead, Flush_i, Hold_i,
    input  IDEX_Rs1, IDEX_Rs2, EXMEM_Rd, EXMEM_RegWrite, MEMWB_Rd,
           MEMWB_RegWrite, Stall_o, PCWrite_o, IFIDWrite_o
  );

  modport slave (
    input  ID_Valid, ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, ID_Rd,
           ID_RegWrite, ID_MemRead, Flush_i, Hold_i,
    output IDEX_Rs1, IDEX_Rs2, EXMEM_Rd, EXMEM_RegWrite, MEMWB_Rd,
           MEMWB_RegWrite, Stall_o, PCWrite_o, IFIDWrite_o
  );
`endif
endinterface

// File: rtl/pipe_tag_tracker.sv
// Destination-tag pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, flush and hold.
// Define TAG_PERF_CNT_EN to add saturating stall/flush cycle counters.
module pipe_tag_tracker #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_tag_tracker_if.slave bus
);

  localparam logic [REG_AW-1:0] LP_ZERO = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } idex_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
  } wr_t;

  idex_t r_idex;
  wr_t   r_exmem;
  wr_t   r_memwb;

  idex_t w_idex_nxt;
  logic  w_src1_hit;
  logic  w_src2_hit;
  logic  w_hz;
  logic  w_stall;
  logic  w_bubble;

  always_comb begin
    w_src1_hit = bus.ID_UseRs1 && (bus.ID_Rs1 == r_idex.rd);
    w_src2_hit = bus.ID_UseRs2 && (bus.ID_Rs2 == r_idex.rd);
    w_hz       = bus.ID_Valid && r_idex.mr && (r_idex.rd != LP_ZERO)
                 && (w_src1_hit || w_src2_hit);
    // Flush squashes the consumer, so a hazard against it is moot.
    w_stall    = w_hz && !bus.Flush_i;
    w_bubble   = bus.Flush_i || w_stall || !bus.ID_Valid;
  end

  always_comb begin
    w_idex_nxt = '0;
    if (!w_bubble) begin
      w_idex_nxt.rs1 = bus.ID_Rs1;
      w_idex_nxt.rs2 = bus.ID_Rs2;
      w_idex_nxt.rd  = bus.ID_Rd;
      w_idex_nxt.rw  = bus.ID_RegWrite && (bus.ID_Rd != LP_ZERO);
      w_idex_nxt.mr  = bus.ID_MemRead;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (!bus.Hold_i) begin
      r_memwb    <= r_exmem;
      r_exmem.rd <= r_idex.rd;
      r_exmem.rw <= r_idex.rw;
      r_idex     <= w_idex_nxt;
    end
  end

  assign bus.IDEX_Rs1       = r_idex.rs1;
  assign bus.IDEX_Rs2       = r_idex.rs2;
  assign bus.EXMEM_Rd       = r_exmem.rd;
  assign bus.EXMEM_RegWrite = r_exmem.rw;
  assign bus.MEMWB_Rd       = r_memwb.rd;
  assign bus.MEMWB_RegWrite = r_memwb.rw;
  assign bus.Stall_o        = w_stall;
  assign bus.PCWrite_o      = !w_stall && !bus.Hold_i;
  assign bus.IFIDWrite_o    = !w_stall && !bus.Hold_i;

`ifdef TAG_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!bus.Hold_i) begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.Flush_i && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.StallCnt_o = r_stall_cnt;
  assign bus.FlushCnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_tag_tracker.sv
// Self-checking bench for pipe_tag_tracker: directed scenarios plus randomized
// traffic against an instruction-level reference model.
module tb_pipe_tag_tracker;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  pipe_tag_tracker_if #(.REG_AW(AW)) bus ();

  pipe_tag_tracker #(.REG_AW(AW), .ZERO_REG(0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the instruction sitting in EX, then the writer tags in MEM and WB.
  typedef struct {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    bit            writes;
    bit            load;
  } ins_t;

  ins_t          m_ex;
  logic [AW-1:0] m_dst [2];
  bit            m_wr  [2];
  longint        m_scnt;
  longint        m_fcnt;

  function automatic bit m_consumer_needs_load();
    bit reads_it;
    reads_it = (bus.ID_UseRs1 && bus.ID_Rs1 == m_ex.rd) ||
               (bus.ID_UseRs2 && bus.ID_Rs2 == m_ex.rd);
    return bus.ID_Valid && m_ex.load && (m_ex.rd != 0) && reads_it;
  endfunction

  function automatic bit m_stall();
    return m_consumer_needs_load() && !bus.Flush_i;
  endfunction

  function automatic bit m_pc_adv();
    return !m_stall() && !bus.Hold_i;
  endfunction

  task automatic step();
    bit st;
    @(posedge clk);
    st = m_stall();
    if (!rst) begin
      m_ex = '{default: 0};
      m_dst[0] = 0; m_dst[1] = 0; m_wr[0] = 0; m_wr[1] = 0;
      m_scnt = 0; m_fcnt = 0;
    end else if (!bus.Hold_i) begin
      if (st && m_scnt != 64'hFFFF_FFFF) m_scnt++;
      if (bus.Flush_i && m_fcnt != 64'hFFFF_FFFF) m_fcnt++;
      m_dst[1] = m_dst[0]; m_wr[1] = m_wr[0];
      m_dst[0] = m_ex.rd;  m_wr[0] = m_ex.writes;
      if (bus.Flush_i || st || !bus.ID_Valid) m_ex = '{default: 0};
      else begin
        m_ex.rs1    = bus.ID_Rs1;
        m_ex.rs2    = bus.ID_Rs2;
        m_ex.rd     = bus.ID_Rd;
        m_ex.writes = bus.ID_RegWrite && (bus.ID_Rd != 0);
        m_ex.load   = bus.ID_MemRead;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input bit u1, input bit u2, input logic [AW-1:0] rd,
                        input bit rw, input bit mr);
    bus.ID_Valid = v;  bus.ID_Rs1 = r1; bus.ID_Rs2 = r2;
    bus.ID_UseRs1 = u1; bus.ID_UseRs2 = u2; bus.ID_Rd = rd;
    bus.ID_RegWrite = rw; bus.ID_MemRead = mr;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.Flush_i = 0;
    bus.Hold_i  = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) begin
      set_id($urandom_range(0, 1), AW'($urandom), AW'($urandom), $urandom_range(0, 1),
             $urandom_range(0, 1), AW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
      bus.Flush_i = $urandom_range(0, 1);
      bus.Hold_i  = 0;
      step();
    end
    #1;
    total++; if (bus.IDEX_Rs1 !== '0) begin bad++; $display("FAIL reset_idex_rs1 got=%0h exp=0", bus.IDEX_Rs1); end
    total++; if (bus.IDEX_Rs2 !== '0) begin bad++; $display("FAIL reset_idex_rs2 got=%0h exp=0", bus.IDEX_Rs2); end
    total++; if (bus.EXMEM_Rd !== '0 || bus.EXMEM_RegWrite !== 1'b0) begin bad++; $display("FAIL reset_exmem got=%0h/%0b exp=0/0", bus.EXMEM_Rd, bus.EXMEM_RegWrite); end
    total++; if (bus.MEMWB_Rd !== '0 || bus.MEMWB_RegWrite !== 1'b0) begin bad++; $display("FAIL reset_memwb got=%0h/%0b exp=0/0", bus.MEMWB_Rd, bus.MEMWB_RegWrite); end
    total++; if (bus.Stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", bus.Stall_o); end
    total++; if (bus.PCWrite_o !== 1'b1 || bus.IFIDWrite_o !== 1'b1) begin bad++; $display("FAIL reset_pcwrite got=%0b/%0b exp=1/1", bus.PCWrite_o, bus.IFIDWrite_o); end
`ifdef TAG_PERF_CNT_EN
    total++; if (bus.StallCnt_o !== 32'd0 || bus.FlushCnt_o !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.StallCnt_o, bus.FlushCnt_o); end
`endif
    rst = 1;
    idle();
    step();
  endtask

  task automatic test_tag_pipeline();
    set_id(1, 1, 2, 0, 0, 5, 1, 0);
    for (int unsigned c = 1; c <= 3; c++) begin
      #1;
      total++; if (bus.Stall_o !== 1'b0) begin bad++; $display("FAIL tag_no_stall cyc=%0d got=%0b exp=0", c, bus.Stall_o); end
      step();
      idle();
    end
    // Three edges after acceptance: MEMWB holds rd 5; check EXMEM one edge earlier too.
    #1;
    total++; if (bus.MEMWB_Rd !== 5'd5 || bus.MEMWB_RegWrite !== 1'b1) begin bad++; $display("FAIL tag_memwb got=%0d/%0b exp=5/1", bus.MEMWB_Rd, bus.MEMWB_RegWrite); end
    set_id(1, 1, 2, 0, 0, 13, 1, 0);
    step(); idle(); step();
    #1;
    total++; if (bus.EXMEM_Rd !== 5'd13 || bus.EXMEM_RegWrite !== 1'b1) begin bad++; $display("FAIL tag_exmem got=%0d/%0b exp=13/1", bus.EXMEM_Rd, bus.EXMEM_RegWrite); end
    repeat (2) step();
  endtask

  task automatic test_load_use();
    set_id(1, 1, 0, 1, 0, 7, 1, 1);
    step();
    set_id(1, 7, 2, 1, 1, 9, 1, 0);
    #1;
    total++; if (bus.Stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", bus.Stall_o); end
    total++; if (bus.PCWrite_o !== 1'b0 || bus.IFIDWrite_o !== 1'b0) begin bad++; $display("FAIL lu_pcwrite got=%0b/%0b exp=0/0", bus.PCWrite_o, bus.IFIDWrite_o); end
    step();
    #1;
    total++; if (bus.IDEX_Rs1 !== '0 || bus.IDEX_Rs2 !== '0) begin bad++; $display("FAIL lu_bubble got=%0d/%0d exp=0/0", bus.IDEX_Rs1, bus.IDEX_Rs2); end
    total++; if (bus.EXMEM_Rd !== 5'd7 || bus.EXMEM_RegWrite !== 1'b1) begin bad++; $display("FAIL lu_exmem got=%0d/%0b exp=7/1", bus.EXMEM_Rd, bus.EXMEM_RegWrite); end
    total++; if (bus.Stall_o !== 1'b0 || bus.PCWrite_o !== 1'b1) begin bad++; $display("FAIL lu_one_cycle got=%0b/%0b exp=0/1", bus.Stall_o, bus.PCWrite_o); end
    step();
    idle();
    #1;
    total++; if (bus.IDEX_Rs1 !== 5'd7 || bus.IDEX_Rs2 !== 5'd2) begin bad++; $display("FAIL lu_consumer_ex got=%0d/%0d exp=7/2", bus.IDEX_Rs1, bus.IDEX_Rs2); end
    repeat (3) step();
  endtask

  task automatic test_zero_unused();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    step();
    set_id(1, 0, 0, 1, 1, 4, 1, 0);
    #1;
    total++; if (bus.Stall_o !== 1'b0) begin bad++; $display("FAIL zero_no_stall got=%0b exp=0", bus.Stall_o); end
    step();
    set_id(1, 0, 0, 0, 0, 3, 1, 1);
    #1;
    total++; if (bus.EXMEM_RegWrite !== 1'b0) begin bad++; $display("FAIL zero_regwrite got=%0b exp=0", bus.EXMEM_RegWrite); end
    step();
    set_id(1, 1, 3, 1, 0, 6, 1, 0);
    #1;
    total++; if (bus.Stall_o !== 1'b0) begin bad++; $display("FAIL unused_rs2 got=%0b exp=0", bus.Stall_o); end
    step();
    idle();
    repeat (3) step();
  endtask

  task automatic test_flush_hazard();
    set_id(1, 0, 0, 0, 0, 8, 1, 1);
    step();
    set_id(1, 8, 1, 1, 1, 2, 1, 0);
    bus.Flush_i = 1;
    #1;
    total++; if (bus.Stall_o !== 1'b0 || bus.PCWrite_o !== 1'b1) begin bad++; $display("FAIL flush_wins got=%0b/%0b exp=0/1", bus.Stall_o, bus.PCWrite_o); end
    step();
    idle();
    #1;
    total++; if (bus.IDEX_Rs1 !== '0 || bus.IDEX_Rs2 !== '0) begin bad++; $display("FAIL flush_bubble got=%0d/%0d exp=0/0", bus.IDEX_Rs1, bus.IDEX_Rs2); end
`ifdef TAG_PERF_CNT_EN
    total++; if (bus.FlushCnt_o !== 32'(m_fcnt)) begin bad++; $display("FAIL flush_count got=%0d exp=%0d", bus.FlushCnt_o, m_fcnt); end
`endif
    repeat (3) step();
  endtask

  task automatic test_hold();
    logic [31:0] scnt_before;
    set_id(1, 1, 2, 0, 0, 10, 1, 0); step();
    set_id(1, 3, 4, 0, 0, 11, 1, 0); step();
    set_id(1, 5, 6, 0, 0, 12, 1, 0);
    bus.Hold_i = 1;
    #1;
    total++; if (bus.PCWrite_o !== 1'b0 || bus.IFIDWrite_o !== 1'b0) begin bad++; $display("FAIL hold_pcwrite got=%0b/%0b exp=0/0", bus.PCWrite_o, bus.IFIDWrite_o); end
    for (int unsigned c = 0; c < 3; c++) begin
      step();
      total++; if (bus.IDEX_Rs1 !== 5'd3 || bus.EXMEM_Rd !== 5'd10) begin bad++; $display("FAIL hold_frozen cyc=%0d got=%0d/%0d exp=3/10", c, bus.IDEX_Rs1, bus.EXMEM_Rd); end
    end
    bus.Hold_i = 0;
    step();
    idle();
    total++; if (bus.IDEX_Rs1 !== 5'd5 || bus.EXMEM_Rd !== 5'd11 || bus.MEMWB_Rd !== 5'd10) begin bad++; $display("FAIL hold_resume got=%0d/%0d/%0d exp=5/11/10", bus.IDEX_Rs1, bus.EXMEM_Rd, bus.MEMWB_Rd); end
    repeat (3) step();
    // Hazard under hold: stall persists while frozen and costs one cycle on release.
    set_id(1, 0, 0, 0, 0, 4, 1, 1); step();
    set_id(1, 1, 4, 0, 1, 2, 1, 0);
    bus.Hold_i = 1;
    scnt_before = 32'(m_scnt);
    repeat (2) step();
    #1;
    total++; if (bus.Stall_o !== 1'b1 || bus.PCWrite_o !== 1'b0) begin bad++; $display("FAIL hold_hazard got=%0b/%0b exp=1/0", bus.Stall_o, bus.PCWrite_o); end
`ifdef TAG_PERF_CNT_EN
    total++; if (bus.StallCnt_o !== scnt_before) begin bad++; $display("FAIL hold_stallcnt got=%0d exp=%0d", bus.StallCnt_o, scnt_before); end
`endif
    bus.Hold_i = 0;
    step();
    #1;
    total++; if (bus.Stall_o !== 1'b0) begin bad++; $display("FAIL hold_release got=%0b exp=0", bus.Stall_o); end
`ifdef TAG_PERF_CNT_EN
    total++; if (bus.StallCnt_o !== scnt_before + 32'd1) begin bad++; $display("FAIL release_stallcnt got=%0d exp=%0d", bus.StallCnt_o, scnt_before + 32'd1); end
`endif
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 0, 0, 0, 0, 9, 1, 1); step();
    set_id(1, 9, 0, 1, 0, 1, 1, 0);
    rst = 0;
    step();
    rst = 1;
    #1;
    total++; if (bus.Stall_o !== 1'b0 || bus.EXMEM_Rd !== '0) begin bad++; $display("FAIL reset_mid_stall got=%0b/%0d exp=0/0", bus.Stall_o, bus.EXMEM_Rd); end
    idle();
    step();
  endtask

  task automatic test_random();
    for (int unsigned c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      set_id($urandom_range(0, 7) != 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
             $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 3)),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      bus.Flush_i = ($urandom_range(0, 7) == 0);
      bus.Hold_i  = ($urandom_range(0, 7) == 0);
      #1;
      total++; if (bus.Stall_o !== m_stall()) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, bus.Stall_o, m_stall()); end
      total++; if (bus.PCWrite_o !== m_pc_adv() || bus.IFIDWrite_o !== m_pc_adv()) begin bad++; $display("FAIL rnd_pcwrite cyc=%0d got=%0b/%0b exp=%0b", c, bus.PCWrite_o, bus.IFIDWrite_o, m_pc_adv()); end
      total++; if (bus.IDEX_Rs1 !== m_ex.rs1 || bus.IDEX_Rs2 !== m_ex.rs2) begin bad++; $display("FAIL rnd_idex cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.IDEX_Rs1, bus.IDEX_Rs2, m_ex.rs1, m_ex.rs2); end
      total++; if (bus.EXMEM_Rd !== m_dst[0] || bus.EXMEM_RegWrite !== m_wr[0]) begin bad++; $display("FAIL rnd_exmem cyc=%0d got=%0d/%0b exp=%0d/%0b", c, bus.EXMEM_Rd, bus.EXMEM_RegWrite, m_dst[0], m_wr[0]); end
      total++; if (bus.MEMWB_Rd !== m_dst[1] || bus.MEMWB_RegWrite !== m_wr[1]) begin bad++; $display("FAIL rnd_memwb cyc=%0d got=%0d/%0b exp=%0d/%0b", c, bus.MEMWB_Rd, bus.MEMWB_RegWrite, m_dst[1], m_wr[1]); end
`ifdef TAG_PERF_CNT_EN
      total++; if (bus.StallCnt_o !== 32'(m_scnt) || bus.FlushCnt_o !== 32'(m_fcnt)) begin bad++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.StallCnt_o, bus.FlushCnt_o, m_scnt, m_fcnt); end
`endif
      step();
    end
    rst = 1;
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_tag_pipeline();
    test_load_use();
    test_zero_unused();
    test_flush_hazard();
    test_hold();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_tag_tracker.md
Name: pipe_tag_tracker

Overview:
- Producer side of the EX-stage forwarding interface.
- Carries destination-register tags and write enables from ID through ID/EX, EX/MEM and MEM/WB, and drives the EXMEM_*/MEMWB_*/IDEX_Rs* signals that forwarding logic consumes.
- Detects load-use hazards, generates the one-cycle stall and inserts the bubble.
- Handles branch flush and global hold; sits beside the pipeline registers in the 5-stage RISC-V core.

Parameters:
- REG_AW, 5, register-address width.
- ZERO_REG, 0, architectural zero register index; never a hazard source or a forwarding target.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous active-low reset.
- ID_Valid  input  1  ID stage holds a real instruction.
- ID_Rs1  input  REG_AW  decoded source 1.
- ID_Rs2  input  REG_AW  decoded source 2.
- ID_UseRs1  input  1  instruction reads Rs1.
- ID_UseRs2  input  1  instruction reads Rs2.
- ID_Rd  input  REG_AW  decoded destination.
- ID_RegWrite  input  1  instruction writes Rd.
- ID_MemRead  input  1  instruction is a load.
- Flush_i  input  1  squash the instruction in ID (taken branch/jump).
- Hold_i  input  1  global freeze (memory wait).
- IDEX_Rs1  output  REG_AW  registered Rs1 of the EX instruction.
- IDEX_Rs2  output  REG_AW  registered Rs2 of the EX instruction.
- EXMEM_Rd  output  REG_AW  Rd in MEM.
- EXMEM_RegWrite  output  1  MEM instruction writes Rd.
- MEMWB_Rd  output  REG_AW  Rd in WB.
- MEMWB_RegWrite  output  1  WB instruction writes Rd.
- Stall_o  output  1  load-use stall this cycle (combinational).
- PCWrite_o  output  1  PC may advance (combinational).
- IFIDWrite_o  output  1  IF/ID may load (combinational).

Behaviour:
- Registered tag stages:
  - IDEX = {Rs1, Rs2, Rd, RegWrite, MemRead}.
  - EXMEM = {Rd, RegWrite}.
  - MEMWB = {Rd, RegWrite}.
- Reset (rst_i==0 at a clk_i edge): all stage fields cleared to 0. All registered outputs read 0 in the cycle after reset.
- Bubble: all IDEX fields = 0.
- Hazard term, combinational:
  - hz = ID_Valid & IDEX_MemRead & (IDEX_Rd!=ZERO_REG) & ((ID_UseRs1 & ID_Rs1==IDEX_Rd) | (ID_UseRs2 & ID_Rs2==IDEX_Rd)).
- Stall_o = hz & ~Flush_i.
- PCWrite_o = IFIDWrite_o = ~Stall_o & ~Hold_i.
- Per clock edge, priority highest first:
  1. Reset.
  2. Hold_i=1: all stages keep their value.
  3. Otherwise MEMWB<=EXMEM and EXMEM<={IDEX_Rd, IDEX_RegWrite}.
  4. IDEX loads a bubble if Flush_i | Stall_o | ~ID_Valid; otherwise it loads the ID fields.
- ID_RegWrite with ID_Rd==ZERO_REG is registered with RegWrite=0.
- Load-use stall lasts exactly 1 cycle: after the bubble IDEX_MemRead=0, so hz drops. The stalled instruction then sees the load in MEM, which the forwarding path covers.
- Back-to-back loads: each dependent consumer costs 1 stall cycle. An independent instruction causes none.
- Flush together with a hazard: Flush_i wins, Stall_o=0, bubble inserted, PC advances.
- Hold together with a hazard: Stall_o is still asserted. Stages are frozen, so the stall persists until Hold_i drops.
- Reset mid-stall: all stages cleared, Stall_o=0 from the next cycle.
- Latency:
  - ID fields appear on IDEX_* 1 cycle after acceptance.
  - They appear on EXMEM_* after 2 cycles and on MEMWB_* after 3 cycles, with no hold.

Optional Feature:
- Macro TAG_PERF_CNT_EN.
- When defined, the block adds the following outputs:
  - StallCnt_o, 32-bit output: counts cycles with Stall_o=1 & Hold_i=0.
  - FlushCnt_o, 32-bit output: counts cycles with Flush_i=1 & Hold_i=0.
- Both counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with random inputs -> all outputs 0, PCWrite_o=1, IFIDWrite_o=1.
- Tag pipeline: issue ID_Rd=5, RegWrite=1, no load -> EXMEM_Rd=5 with RegWrite=1 two cycles later, MEMWB_Rd=5 three cycles later, Stall_o never 1.
- Load-use: lw x7, then add reading Rs1=x7 -> Stall_o=1 for exactly 1 cycle and PCWrite_o=0 that cycle. Next cycle IDEX all-zero, EXMEM_Rd=7; following cycle IDEX_Rs1=7.
- Zero and unused sources: lw x0, then a consumer of x0 -> no stall. lw x3, then addi with Rs2 field=3 and UseRs2=0 -> no stall.
- Flush vs hazard: load-use condition plus Flush_i=1 -> Stall_o=0, PCWrite_o=1, IDEX bubble.
- Hold: with Hold_i=1 for 3 cycles mid-stream -> all tag outputs frozen, PCWrite_o=0. Release -> the sequence resumes unchanged. Under TAG_PERF_CNT_EN, StallCnt_o does not increment during hold.
